// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard controller: register fields and control bits
// from IF/ID, ID/EX, EX/MEM and MEM/WB in, stall/flush/forward controls out.
interface hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  idex_rs;
  logic [4:0]  idex_rt;
  logic        idex_mem_read;
  logic        idex_reg_write;
  logic [4:0]  idex_write_reg;
  logic [4:0]  exmem_write_reg;
  logic        exmem_reg_write;
  logic        exmem_branch_taken;
  logic        exmem_jump;
  logic [4:0]  memwb_write_reg;
  logic        memwb_reg_write;
  logic        halt_req;

  logic [1:0]  forward_a;
  logic [1:0]  forward_b;
  logic        pc_write;
  logic        if_id_write;
  logic        id_ex_bubble;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic        flush_ex_mem;
  logic        pc_redirect;
  logic [1:0]  state;
  logic [15:0] stall_count;
  logic [15:0] flush_count;

  // Every signal is level-sensitive and sampled at the rising clock edge; there is
  // no valid/ready pairing: control outputs apply to the edge that ends the cycle.
  modport slave (
    input  id_rs, id_rt, idex_rs, idex_rt, idex_mem_read, idex_reg_write,
           idex_write_reg, exmem_write_reg, exmem_reg_write, exmem_branch_taken,
           exmem_jump, memwb_write_reg, memwb_reg_write, halt_req,
    output forward_a, forward_b, pc_write, if_id_write, id_ex_bubble,
           flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, state,
           stall_count, flush_count
  );

  modport master (
    output id_rs, id_rt, idex_rs, idex_rt, idex_mem_read, idex_reg_write,
           idex_write_reg, exmem_write_reg, exmem_reg_write, exmem_branch_taken,
           exmem_jump, memwb_write_reg, memwb_reg_write, halt_req,
    input  forward_a, forward_b, pc_write, if_id_write, id_ex_bubble,
           flush_if_id, flush_id_ex, flush_ex_mem, pc_redirect, state,
           stall_count, flush_count
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline: operand forwarding, load-use stall,
// branch/jump flush and external halt, with saturating event counters.
module hazard_ctrl (
  input  logic           clock,
  input  logic           reset,
  hazard_ctrl_if.slave   hz
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_stall_count;
  logic [15:0] r_flush_count;

  logic        w_load_use;
  logic        w_redirect;
  logic        w_stall_inc;
  logic        w_flush_inc;
  logic        w_pc_write;
  logic        w_if_id_write;
  logic        w_id_ex_bubble;
  logic        w_flush_all;
  logic [1:0]  w_fwd_a;
  logic [1:0]  w_fwd_b;
  logic        w_unused;

  // ID/EX write enable plays no part in these hazard rules.
  assign w_unused = hz.idex_reg_write;

  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic       exmem_we,
    input logic [4:0] exmem_rd,
    input logic       memwb_we,
    input logic [4:0] memwb_rd
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src)) begin
      sel = 2'b10;
    end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == src)) begin
      sel = 2'b01;
    end
    return sel;
  endfunction

  assign w_fwd_a = fwd_sel(hz.idex_rs, hz.exmem_reg_write, hz.exmem_write_reg,
                           hz.memwb_reg_write, hz.memwb_write_reg);
  assign w_fwd_b = fwd_sel(hz.idex_rt, hz.exmem_reg_write, hz.exmem_write_reg,
                           hz.memwb_reg_write, hz.memwb_write_reg);

  assign w_load_use = hz.idex_mem_read && (hz.idex_write_reg != 5'd0) &&
                      ((hz.idex_write_reg == hz.id_rs) || (hz.idex_write_reg == hz.id_rt));
  assign w_redirect = hz.exmem_branch_taken || hz.exmem_jump;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Reset forces the idle output pattern regardless of the registered state.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_write     = 1'b1;
    w_if_id_write  = 1'b1;
    w_id_ex_bubble = 1'b0;
    w_flush_all    = 1'b0;
    w_stall_inc    = 1'b0;
    w_flush_inc    = 1'b0;
    if (!reset) begin
      case (r_state)
        ST_RUN: begin
          if (w_redirect) begin
            w_flush_all = 1'b1;
            w_flush_inc = 1'b1;
            w_state_nxt = ST_FLUSH;
          end else if (w_load_use) begin
            w_pc_write     = 1'b0;
            w_if_id_write  = 1'b0;
            w_id_ex_bubble = 1'b1;
            w_stall_inc    = 1'b1;
          end else if (hz.halt_req) begin
            w_state_nxt = ST_HALT;
          end
        end
        ST_FLUSH: begin
          w_state_nxt = ST_RUN;
        end
        ST_HALT: begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
          w_stall_inc    = 1'b1;
          if (!hz.halt_req) begin
            w_state_nxt = ST_RUN;
          end
        end
        default: begin
          w_state_nxt = ST_RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= 16'd0;
      r_flush_count <= 16'd0;
    end else begin
      if (w_stall_inc && (r_stall_count != 16'hFFFF)) begin
        r_stall_count <= r_stall_count + 16'd1;
      end
      if (w_flush_inc && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign hz.forward_a    = reset ? 2'b00 : w_fwd_a;
  assign hz.forward_b    = reset ? 2'b00 : w_fwd_b;
  assign hz.pc_write     = w_pc_write;
  assign hz.if_id_write  = w_if_id_write;
  assign hz.id_ex_bubble = w_id_ex_bubble;
  assign hz.flush_if_id  = w_flush_all;
  assign hz.flush_id_ex  = w_flush_all;
  assign hz.flush_ex_mem = w_flush_all;
  assign hz.pc_redirect  = w_flush_all;
  assign hz.state        = r_state;
  assign hz.stall_count  = r_stall_count;
  assign hz.flush_count  = r_flush_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed and random vectors, a behavioural model
// producing the expected per-cycle outputs, and a scoreboard monitor.
module tb_hazard_ctrl;

  localparam int W = 45;

  logic clk;
  logic rst;

  hazard_ctrl_if hz();

  hazard_ctrl u_dut (
    .clock (clk),
    .reset (rst),
    .hz    (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rs, idex_rt, idex_write_reg;
    logic [4:0] exmem_write_reg, memwb_write_reg;
    logic       idex_mem_read, idex_reg_write, exmem_reg_write;
    logic       exmem_branch_taken, exmem_jump, memwb_reg_write, halt_req;
  } stim_t;

  logic [W-1:0] exp_q[$];
  int           n_vec  = 0;
  int           n_miss = 0;
  int           n_cyc  = 0;

  // Model state: 0 = RUN, 1 = FLUSH (one cycle after redirect), 2 = HALT.
  int           m_mode;
  logic [15:0]  m_stall;
  logic [15:0]  m_flush;
  int           halt_left = 0;

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0;
    s.id_rs = 5'd0; s.id_rt = 5'd0; s.idex_rs = 5'd0; s.idex_rt = 5'd0;
    s.idex_write_reg = 5'd0; s.exmem_write_reg = 5'd0; s.memwb_write_reg = 5'd0;
    s.idex_mem_read = 1'b0; s.idex_reg_write = 1'b0; s.exmem_reg_write = 1'b0;
    s.exmem_branch_taken = 1'b0; s.exmem_jump = 1'b0; s.memwb_reg_write = 1'b0;
    s.halt_req = 1'b0;
    return s;
  endfunction

  function automatic logic [1:0] model_fwd(input stim_t s, input logic [4:0] src);
    if (s.exmem_reg_write && s.exmem_write_reg != 0 && s.exmem_write_reg == src) return 2'b10;
    if (s.memwb_reg_write && s.memwb_write_reg != 0 && s.memwb_write_reg == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  task automatic drive(input stim_t s);
    rst = s.rst;
    hz.id_rs = s.id_rs; hz.id_rt = s.id_rt; hz.idex_rs = s.idex_rs; hz.idex_rt = s.idex_rt;
    hz.idex_write_reg = s.idex_write_reg; hz.exmem_write_reg = s.exmem_write_reg;
    hz.memwb_write_reg = s.memwb_write_reg; hz.idex_mem_read = s.idex_mem_read;
    hz.idex_reg_write = s.idex_reg_write; hz.exmem_reg_write = s.exmem_reg_write;
    hz.exmem_branch_taken = s.exmem_branch_taken; hz.exmem_jump = s.exmem_jump;
    hz.memwb_reg_write = s.memwb_reg_write; hz.halt_req = s.halt_req;
  endtask

  // One cycle: drive, predict this cycle's outputs, advance the model past the edge.
  task automatic apply(input stim_t s);
    logic [1:0] fa, fb;
    logic       stall, flush;
    logic       lu, redir;
    int         nxt;
    @(posedge clk);
    #1;
    drive(s);
    lu    = s.idex_mem_read && s.idex_write_reg != 0 &&
            (s.idex_write_reg == s.id_rs || s.idex_write_reg == s.id_rt);
    redir = s.exmem_branch_taken || s.exmem_jump;
    fa = s.rst ? 2'b00 : model_fwd(s, s.idex_rs);
    fb = s.rst ? 2'b00 : model_fwd(s, s.idex_rt);
    stall = 1'b0;
    flush = 1'b0;
    nxt   = m_mode;
    if (!s.rst) begin
      if (m_mode == 0) begin
        if (redir) begin flush = 1'b1; nxt = 1; end
        else if (lu) stall = 1'b1;
        else if (s.halt_req) nxt = 2;
      end else if (m_mode == 1) begin
        nxt = 0;
      end else begin
        stall = 1'b1;
        if (!s.halt_req) nxt = 0;
      end
    end
    exp_q.push_back({fa, fb, ~stall, ~stall, stall, flush, flush, flush, flush,
                     2'(m_mode), m_stall, m_flush});
    if (s.rst) begin
      m_mode = 0; m_stall = 16'd0; m_flush = 16'd0;
    end else begin
      m_mode = nxt;
      if (stall) m_stall = sat_inc(m_stall);
      if (flush) m_flush = sat_inc(m_flush);
    end
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.id_rs = 5'($urandom_range(0, 3)); s.id_rt = 5'($urandom_range(0, 3));
    s.idex_rs = 5'($urandom_range(0, 3)); s.idex_rt = 5'($urandom_range(0, 3));
    s.idex_write_reg = 5'($urandom_range(0, 3));
    s.exmem_write_reg = 5'($urandom_range(0, 3));
    s.memwb_write_reg = 5'($urandom_range(0, 3));
    s.idex_mem_read = ($urandom_range(0, 2) == 0);
    s.idex_reg_write = 1'($urandom_range(0, 1));
    s.exmem_reg_write = 1'($urandom_range(0, 1));
    s.memwb_reg_write = 1'($urandom_range(0, 1));
    s.exmem_branch_taken = ($urandom_range(0, 11) == 0);
    s.exmem_jump = ($urandom_range(0, 15) == 0);
    s.rst = ($urandom_range(0, 199) == 0);
    return s;
  endfunction

  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] exp;
    n_cyc++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      act = {hz.forward_a, hz.forward_b, hz.pc_write, hz.if_id_write, hz.id_ex_bubble,
             hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem, hz.pc_redirect,
             hz.state, hz.stall_count, hz.flush_count};
      n_vec++;
      if (act !== exp) begin
        n_miss++;
        $display("FAIL outputs cycle %0d: got fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b%b%b red=%b st=%b sc=%h fc=%h, expected fa=%b fb=%b pcw=%b ifw=%b bub=%b fl=%b%b%b red=%b st=%b sc=%h fc=%h",
                 n_cyc, act[44:43], act[42:41], act[40], act[39], act[38], act[37], act[36],
                 act[35], act[34], act[33:32], act[31:16], act[15:0],
                 exp[44:43], exp[42:41], exp[40], exp[39], exp[38], exp[37], exp[36],
                 exp[35], exp[34], exp[33:32], exp[31:16], exp[15:0]);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    s.rst = 1'b1;
    drive(s);
    repeat (2) @(posedge clk);
    m_mode = 0; m_stall = 16'd0; m_flush = 16'd0;

    apply(s);                     // reset held: idle output pattern
    apply(idle());

    s = idle();                   // load-use on id_rs
    s.idex_mem_read = 1'b1; s.idex_write_reg = 5'd8; s.id_rs = 5'd8;
    apply(s);
    apply(idle());

    s = idle();                   // forwarding priority, then MEM/WB only
    s.exmem_reg_write = 1'b1; s.exmem_write_reg = 5'd5;
    s.memwb_reg_write = 1'b1; s.memwb_write_reg = 5'd5;
    s.idex_rs = 5'd5; s.idex_rt = 5'd5;
    apply(s);
    s.exmem_write_reg = 5'd0;
    apply(s);

    s = idle();                   // redirect beats load-use, load-use masked in FLUSH
    s.exmem_branch_taken = 1'b1;
    s.idex_mem_read = 1'b1; s.idex_write_reg = 5'd3; s.id_rt = 5'd3;
    apply(s);
    s.exmem_branch_taken = 1'b0;
    apply(s);
    apply(idle());

    s = idle();                   // halt for four cycles
    s.halt_req = 1'b1;
    repeat (4) apply(s);
    repeat (2) apply(idle());

    s = idle();                   // reset mid-HALT with stall_count at 7
    s.rst = 1'b1;
    apply(s);
    s = idle();
    s.halt_req = 1'b1;
    repeat (8) apply(s);
    s.rst = 1'b1;
    apply(s);
    repeat (2) apply(idle());

    repeat (1500) begin
      s = rand_stim();
      if (halt_left > 0) begin
        s.halt_req = 1'b1;
        halt_left--;
      end else if ($urandom_range(0, 24) == 0) begin
        halt_left = $urandom_range(1, 6);
      end
      apply(s);
    end

    s = idle();                   // drive stall_count to 16'hFFFE, then saturate
    s.rst = 1'b1;
    apply(s);
    s = idle();
    s.halt_req = 1'b1;
    repeat (65534) apply(s);
    apply(idle());
    s = idle();
    s.idex_mem_read = 1'b1; s.idex_write_reg = 5'd9; s.id_rs = 5'd9;
    repeat (3) apply(s);
    repeat (2) apply(idle());

    s = idle();
    s.rst = 1'b1;
    apply(s);
    apply(idle());

    repeat (2) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset.
REQ-002 clock  in  1  rising-edge clock shared with all pipeline registers.
REQ-003 reset  in  1  synchronous, active-high; sampled on the rising edge of clock.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in IF/ID.
REQ-005 idex_rs, idex_rt  in  5 each  source register fields held in ID/EX.
REQ-006 idex_mem_read, idex_reg_write  in  1 each  ID/EX control bits.
REQ-007 idex_write_reg  in  5  destination selected in EX (rd or rt).
REQ-008 exmem_write_reg  in  5; exmem_reg_write  in  1  EX/MEM destination and write enable.
REQ-009 exmem_branch_taken  in  1  (BranchEq & Zero) | (BranchNeq & ~Zero), EX/MEM stage.
REQ-010 exmem_jump  in  1  jump flag in EX/MEM.
REQ-011 memwb_write_reg  in  5; memwb_reg_write  in  1  MEM/WB destination and write enable.
REQ-012 halt_req  in  1  external request to freeze the front end.
REQ-013 forward_a, forward_b  out  2 each  ALU operand select: 00 register file, 10 EX/MEM ALUResult, 01 MEM/WB write-back data.
REQ-014 pc_write, if_id_write  out  1 each  enables for PC and IF/ID.
REQ-015 id_ex_bubble  out  1  load zeros into ID/EX control bits at next edge.
REQ-016 flush_if_id, flush_id_ex, flush_ex_mem  out  1 each  clear the named register's control bits at next edge.
REQ-017 pc_redirect  out  1  PC mux selects the EX/MEM target (branch or jump).
REQ-018 state  out  2  FSM state: RUN=00, FLUSH=01, HALT=10.
REQ-019 stall_count, flush_count  out  16 each  event counters.

Function
REQ-020 Forwarding SHALL be combinational: forward_a=10 when exmem_reg_write, exmem_write_reg!=0 and exmem_write_reg==idex_rs; else 01 when the same holds for MEM/WB; else 00. forward_b uses idex_rt identically; EX/MEM has priority over MEM/WB.
REQ-021 load_use SHALL be idex_mem_read & (idex_write_reg!=0) & (idex_write_reg==id_rs | idex_write_reg==id_rt).
REQ-022 redirect SHALL be exmem_branch_taken | exmem_jump.
REQ-023 RUN, redirect: pc_redirect=1, all three flush outputs=1, pc_write=1, if_id_write=1, id_ex_bubble=0; next state FLUSH; flush_count +1.
REQ-024 RUN, load_use, no redirect: pc_write=0, if_id_write=0, id_ex_bubble=1 for exactly that cycle; state stays RUN; stall_count +1.
REQ-025 RUN, halt_req, no redirect, no load_use: next state HALT; that cycle behaves as normal RUN.
REQ-026 RUN, none of the above: pc_write=1, if_id_write=1, all bubble/flush/redirect outputs 0.
REQ-027 FLUSH SHALL last exactly one cycle; load_use, redirect and halt_req are masked; outputs as REQ-026; next state RUN.
REQ-028 HALT: pc_write=0, if_id_write=0, id_ex_bubble=1 every cycle; stall_count +1 per cycle; next state RUN when halt_req=0 at the edge.
REQ-029 Priority in RUN SHALL be redirect > load_use > halt_req.
REQ-030 Both counters SHALL saturate at 16'hFFFF, with no wrap.
REQ-031 Forwarding outputs SHALL follow REQ-020 in every state.

Reset
REQ-032 A reset edge SHALL set state=RUN and stall_count=flush_count=0, overriding any transition or count in that cycle, including mid-HALT and mid-FLUSH.
REQ-033 While reset=1, outputs SHALL be: pc_write=1, if_id_write=1, all bubble/flush/redirect outputs 0, forward_a=forward_b=00.

Verification
REQ-034 idex_mem_read=1, idex_write_reg=8, id_rs=8 in RUN -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1; state stays 00.
REQ-035 exmem_reg_write=1, exmem_write_reg=5, memwb_reg_write=1, memwb_write_reg=5, idex_rs=5, idex_rt=5 -> forward_a=forward_b=10; with exmem_write_reg=0 instead -> both 01.
REQ-036 exmem_branch_taken=1 and load_use both true in RUN -> pc_redirect=1, three flushes=1, id_ex_bubble=0; next cycle state=01 with load_use masked; flush_count +1, stall_count unchanged.
REQ-037 halt_req=1 for 4 cycles from RUN -> state 10 for 4 cycles, pc_write=0 throughout, stall_count +4; RUN one cycle after halt_req drops.
REQ-038 stall_count preloaded to 16'hFFFE, then 3 stall events -> counter holds 16'hFFFF.
REQ-039 reset asserted during HALT with stall_count=7 -> after the edge state=00 and stall_count=0; outputs per REQ-033 while reset=1.
